// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT_MAX valid products per window and pulses out_valid with the sum.
// Optional SATURATE_EN: clamp the accumulator on carry instead of wrapping.
module product_accumulator #(
  parameter int P_WIDTH = 16,
  parameter int ACC_WIDTH = 24,
  parameter int COUNT_MAX = 16,
  localparam int CNT_W = $clog2(COUNT_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [P_WIDTH-1:0]   in_P,
  input  logic                 in_valid,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     out_count,
  output logic                 overflow
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, out_acc_q, out_acc_d, acc_add;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [ACC_WIDTH:0] ext, sum;
  always_comb begin
    ext = {{(ACC_WIDTH + 1 - P_WIDTH){1'b0}}, in_P};
    sum = {1'b0, acc_q} + ext;
`ifdef SATURATE_EN
    acc_add = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
    acc_add = sum[ACC_WIDTH-1:0];
`endif
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    out_acc_d = out_acc_q;
    if (clear) begin
      state_d = IDLE;
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == ACC && in_valid) begin
      acc_d = acc_add;
      cnt_d = cnt_q + 1'b1;
      ovf_d = ovf_q | sum[ACC_WIDTH];
      if (cnt_q == CNT_W'(COUNT_MAX - 1)) begin
        state_d = DONE;
        out_acc_d = acc_add;
      end
    end else if (state_q != ACC && in_valid) begin
      acc_d = ext[ACC_WIDTH-1:0];
      cnt_d = CNT_W'(1);
      ovf_d = 1'b0;
      state_d = (COUNT_MAX == 1) ? DONE : ACC;
      out_acc_d = (COUNT_MAX == 1) ? ext[ACC_WIDTH-1:0] : out_acc_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      out_acc_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      out_acc_q <= out_acc_d;
    end
  end
  assign out_acc = out_acc_q;
  assign out_valid = (state_q == DONE);
  assign out_count = cnt_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed checks of windowing, gaps, back-to-back, overflow, clear and async reset.
module tb_product_accumulator;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clear = 1'b0;
  logic [15:0] in_P = '0;
  logic [23:0] a_acc;
  logic a_vld, a_ovf;
  logic [2:0] a_cnt;
  logic [16:0] b_acc;
  logic b_vld, b_ovf;
  logic [2:0] b_cnt;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  product_accumulator #(.P_WIDTH(16), .ACC_WIDTH(24), .COUNT_MAX(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_P(in_P), .in_valid(in_valid), .clear(clear),
    .out_acc(a_acc), .out_valid(a_vld), .out_count(a_cnt), .overflow(a_ovf));
  product_accumulator #(.P_WIDTH(16), .ACC_WIDTH(17), .COUNT_MAX(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_P(in_P), .in_valid(in_valid), .clear(clear),
    .out_acc(b_acc), .out_valid(b_vld), .out_count(b_cnt), .overflow(b_ovf));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [15:0] p, input logic v, input logic c = 1'b0);
    @(negedge clk);
    in_P = p;
    in_valid = v;
    clear = c;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic [23:0] acc, input logic vld, input logic [2:0] cnt, input logic ovf);
    chk({tag, ".acc"}, 32'(a_acc), 32'(acc));
    chk({tag, ".vld"}, 32'(a_vld), 32'(vld));
    chk({tag, ".cnt"}, 32'(a_cnt), 32'(cnt));
    chk({tag, ".ovf"}, 32'(a_ovf), 32'(ovf));
  endtask
  initial begin
    logic [15:0] v1 [4] = '{16'd3, 16'd5, 16'd7, 16'd9};
    logic [16:0] sat_exp;
`ifdef SATURATE_EN
    sat_exp = 17'h1FFFF;
`else
    sat_exp = 17'h1FFFC;
`endif
    #12;
    chk_a("reset", 24'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(v1[i], 1'b1);
      chk_a("t1.partial", 24'd0, 1'b0, 3'(i + 1), 1'b0);
    end
    step(v1[3], 1'b1);
    chk_a("t1.done", 24'd24, 1'b1, 3'd4, 1'b0);
    step(16'd0, 1'b0);
    chk_a("t1.after", 24'd24, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(v1[i], 1'b1);
      chk_a("t2.sample", (i == 3) ? 24'd24 : 24'd24, i == 3, 3'(i + 1), 1'b0);
      if (i < 3) begin
        step(16'd0, 1'b0);
        step(16'd0, 1'b0);
        chk_a("t2.gap", 24'd24, 1'b0, 3'(i + 1), 1'b0);
      end
    end
    step(16'd0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(16'(i), 1'b1);
      if (i == 4) chk_a("t3.first", 24'd10, 1'b1, 3'd4, 1'b0);
      if (i == 5) chk_a("t3.restart", 24'd10, 1'b0, 3'd1, 1'b0);
      if (i == 8) chk_a("t3.second", 24'd26, 1'b1, 3'd4, 1'b0);
    end
    step(16'd0, 1'b0);
    chk("t3.idle_vld", 32'(a_vld), 32'd0);
    for (int i = 0; i < 4; i++) step(16'hFFFF, 1'b1);
    chk("t4.acc17", 32'(b_acc), 32'(sat_exp));
    chk("t4.ovf17", 32'(b_ovf), 32'd1);
    chk("t4.vld17", 32'(b_vld), 32'd1);
    chk_a("t4.acc24", 24'h03FFFC, 1'b1, 3'd4, 1'b0);
    step(16'd0, 1'b0);
    chk("t4.ovf_hold", 32'(b_ovf), 32'd1);
    step(16'd1, 1'b1);
    chk("t4.ovf_clr", 32'(b_ovf), 32'd0);
    for (int i = 0; i < 3; i++) step(16'd1, 1'b1);
    chk("t4.clean17", 32'(b_acc), 32'd4);
    chk("t4.clean_ovf", 32'(b_ovf), 32'd0);
    step(16'd0, 1'b0);
    step(16'd2, 1'b1);
    step(16'd2, 1'b1);
    chk_a("t5.pre", 24'd4, 1'b0, 3'd2, 1'b0);
    step(16'd100, 1'b1, 1'b1);
    chk_a("t5.clear", 24'd4, 1'b0, 3'd0, 1'b0);
    step(16'd0, 1'b0);
    chk_a("t5.idle", 24'd4, 1'b0, 3'd0, 1'b0);
    step(16'd5, 1'b1);
    step(16'd5, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_a("t6.async", 24'd0, 1'b0, 3'd0, 1'b0);
    chk("t6.acc17", 32'(b_acc), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) step(16'(i), 1'b1);
    chk_a("t6.window", 24'd10, 1'b1, 3'd4, 1'b0);
    step(16'd0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
